regfile_dump: RTL

Debug read-out engine for the 16 x 32-bit CPU register file. On a start pulse it walks a contiguous (wrapping) index range through the register file's read port and streams each register out as four little-endian bytes over a valid/ready byte interface. The debug UART or scan link consumes that stream. It is the reading counterpart to the register-file write path; `busy` lets the core hold off register writes during a dump.

---
 rtl/regdump_pkg.sv | 17 +
 rtl/regdump_serializer.sv | 45 ++++
 rtl/regfile_dump.sv | 108 ++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump engine.
package regdump_pkg;

  // Dump sequencer states; StCsum is only entered when REGDUMP_CSUM_EN is defined.
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StSend,
    StCsum,
    StDone
  } state_t;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned BYTES_PER_REG  = DEFAULT_DATA_W / 8;
  localparam int unsigned REG_COUNT      = 16;

endpackage

// File: rtl/regdump_serializer.sv
// Loads one register word and shifts it out LSB byte first over valid/ready.
module regdump_serializer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              last_byte_accepted
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              hs;

  assign hs                 = tx_valid && tx_ready;
  assign tx_data            = shreg[7:0];
  assign last_byte_accepted = hs && (cnt == CW'(NB - 1));

  // Word load, then one byte shift per accepted handshake; data only moves on hs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= word;
      cnt      <= '0;
      tx_valid <= 1'b1;
    end else if (hs) begin
      shreg <= shreg >> 8;
      cnt   <= cnt + 1'b1;
      if (last_byte_accepted) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks a wrapping index range and streams each
// register as little-endian bytes. Optional trailing checksum byte when the
// macro REGDUMP_CSUM_EN is defined.
module regfile_dump
  import regdump_pkg::*;
#(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  last_idx,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [7:0]       ser_data;
  logic             ser_valid;
  logic             ser_last;

  regdump_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk                (clk),
    .rst                (rst),
    .load               (state == StAddr),
    .word               (rd_data),
    .tx_ready           (tx_ready),
    .tx_data            (ser_data),
    .tx_valid           (ser_valid),
    .last_byte_accepted (ser_last)
  );

  assign busy = (state != StIdle);
  assign done = (state == StDone);

`ifdef REGDUMP_CSUM_EN
  logic [7:0] csum;

  // Checksum accumulates every accepted data byte; it is presented in StCsum.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (state == StIdle && start) begin
      csum <= '0;
    end else if (state == StSend && ser_valid && tx_ready) begin
      csum <= csum + ser_data;
    end
  end

  assign tx_data  = (state == StCsum) ? csum : ser_data;
  assign tx_valid = ser_valid || (state == StCsum);
`else
  assign tx_data  = ser_data;
  assign tx_valid = ser_valid;
`endif

  // Dump sequencer: address phase, byte send phase, optional checksum, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= StIdle;
      rd_idx <= '0;
      last   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            rd_idx <= first_idx;
            last   <= last_idx;
            state  <= StAddr;
          end
        end
        StAddr: state <= StSend;
        StSend: begin
          if (ser_last) begin
            if (rd_idx != last) begin
              rd_idx <= rd_idx + 1'b1;
              state  <= StAddr;
            end else begin
`ifdef REGDUMP_CSUM_EN
              state <= StCsum;
`else
              state <= StDone;
`endif
            end
          end
        end
        StCsum: begin
          if (tx_ready) begin
            state <= StDone;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule
